// File: rtl/inlet_dispense_sequencer.sv
// Inlet dispense sequencer: queued host commands drive the valve select and the pump step pulses.
// Optional macro ABORT_DISPENSE_EN adds an abort input that cuts short an active dispense.
module inlet_dispense_sequencer #(
   parameter int CMD_DEPTH  = 4,
   parameter int NUM_CH     = 8,
   parameter int CH_W       = 3,
   parameter int VOL_W      = 12,
   parameter int STEP_DIV   = 16,
   parameter int VALVE_LEAD = 2,
   parameter int SETTLE_CYC = 8
) (
   input  logic              clk,
   input  logic              rst,
`ifdef ABORT_DISPENSE_EN
   input  logic              abort,
`endif
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [CH_W-1:0]   cmd_chan,
   input  logic [VOL_W-1:0]  cmd_vol,
   output logic [NUM_CH-1:0] valve_sel,
   output logic              pump_step,
   output logic              busy,
   output logic              done_pulse,
   output logic              err_pulse,
   output logic [VOL_W-1:0]  steps_done
);

   localparam int AW      = $clog2(CMD_DEPTH);
   localparam int CNT_MAX = (STEP_DIV > VALVE_LEAD)
                            ? ((STEP_DIV > SETTLE_CYC) ? STEP_DIV : SETTLE_CYC)
                            : ((VALVE_LEAD > SETTLE_CYC) ? VALVE_LEAD : SETTLE_CYC);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {IDLE, OPEN, PUMP, SETTLE} state_t;

   logic [CH_W-1:0]  mem_chan [CMD_DEPTH];
   logic [VOL_W-1:0] mem_vol  [CMD_DEPTH];
   logic [AW:0]      wr_ptr, rd_ptr;
   logic             empty, full, push, pop;
   logic [CH_W-1:0]  head_chan;
   logic [VOL_W-1:0] head_vol;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [VOL_W-1:0] vol_lat, vol_n, steps_n;
   logic [NUM_CH-1:0] valve_n;
   logic             pump_n, done_n, err_n, abort_req;

`ifdef ABORT_DISPENSE_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign cmd_ready = !full;
   assign push      = cmd_valid && !full;
   assign head_chan = mem_chan[rd_ptr[AW-1:0]];
   assign head_vol  = mem_vol[rd_ptr[AW-1:0]];
   assign busy      = (state != IDLE) || !empty;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_chan[wr_ptr[AW-1:0]] <= cmd_chan;
         mem_vol[wr_ptr[AW-1:0]]  <= cmd_vol;
      end
      vol_lat <= vol_n;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      valve_n = valve_sel;
      steps_n = steps_done;
      vol_n   = vol_lat;
      pump_n  = 1'b0;
      done_n  = 1'b0;
      err_n   = 1'b0;
      pop     = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop = 1'b1;
               if (32'(head_chan) >= NUM_CH) begin
                  err_n = 1'b1;
               end else if (head_vol == '0) begin
                  done_n = 1'b1;
               end else begin
                  state_n = OPEN;
                  cnt_n   = '0;
                  valve_n = NUM_CH'(1) << head_chan;
                  steps_n = '0;
                  vol_n   = head_vol;
               end
            end
         end
         OPEN: begin
            if (abort_req) begin
               state_n = SETTLE;
               cnt_n   = '0;
               valve_n = '0;
            end else if (cnt == CNT_W'(VALVE_LEAD - 1)) begin
               state_n = PUMP;
               cnt_n   = '0;
               pump_n  = 1'b1;
               steps_n = steps_done + 1'b1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         PUMP: begin
            // Each step owns a full STEP_DIV window; the last window runs out before settling.
            if (abort_req) begin
               state_n = SETTLE;
               cnt_n   = '0;
               valve_n = '0;
            end else if (cnt == CNT_W'(STEP_DIV - 1)) begin
               cnt_n = '0;
               if (steps_done == vol_lat) begin
                  state_n = SETTLE;
                  valve_n = '0;
               end else begin
                  pump_n  = 1'b1;
                  steps_n = steps_done + 1'b1;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         SETTLE: begin
            if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
               state_n = IDLE;
               cnt_n   = '0;
               done_n  = 1'b1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
            valve_n = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         valve_sel  <= '0;
         pump_step  <= 1'b0;
         done_pulse <= 1'b0;
         err_pulse  <= 1'b0;
         steps_done <= '0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         valve_sel  <= valve_n;
         pump_step  <= pump_n;
         done_pulse <= done_n;
         err_pulse  <= err_n;
         steps_done <= steps_n;
      end
   end

endmodule

// File: tb/tb_inlet_dispense_sequencer.sv
// Scoreboard bench for inlet_dispense_sequencer: random commands against a per-command dispense model.
module tb_inlet_dispense_sequencer;

   localparam int CMD_DEPTH  = 4;
   localparam int NUM_CH     = 8;
   localparam int CH_W       = 4;
   localparam int VOL_W      = 12;
   localparam int STEP_DIV   = 16;
   localparam int VALVE_LEAD = 2;
   localparam int SETTLE_CYC = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [CH_W-1:0]   cmd_chan;
   logic [VOL_W-1:0]  cmd_vol;
   logic [NUM_CH-1:0] valve_sel;
   logic              pump_step, busy, done_pulse, err_pulse;
   logic [VOL_W-1:0]  steps_done;
`ifdef ABORT_DISPENSE_EN
   logic              abort;
`endif

   inlet_dispense_sequencer #(
      .CMD_DEPTH(CMD_DEPTH), .NUM_CH(NUM_CH), .CH_W(CH_W), .VOL_W(VOL_W),
      .STEP_DIV(STEP_DIV), .VALVE_LEAD(VALVE_LEAD), .SETTLE_CYC(SETTLE_CYC)
   ) dut (
      .clk(clk), .rst(rst),
`ifdef ABORT_DISPENSE_EN
      .abort(abort),
`endif
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_chan(cmd_chan), .cmd_vol(cmd_vol),
      .valve_sel(valve_sel), .pump_step(pump_step), .busy(busy),
      .done_pulse(done_pulse), .err_pulse(err_pulse), .steps_done(steps_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit err;
      int chan;
      int steps;
      int open;
      int settle;
   } exp_t;

   exp_t q[$];
   exp_t e_cur;
   int   n_cmp = 0;
   int   n_fail = 0;
   int   open_cnt, closed_cnt, pump_cnt, since, bad_valve, bad_gap;

   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Reference: a command either errors, completes instantly, or holds the valve for lead + vol windows.
   function automatic exp_t mk(input int c, input int v);
      exp_t r;
      r.err    = (c >= NUM_CH);
      r.chan   = c;
      r.steps  = r.err ? 0 : v;
      r.open   = (r.err || v == 0) ? 0 : VALVE_LEAD + v * STEP_DIV;
      r.settle = (r.open > 0) ? SETTLE_CYC + 1 : 0;
      return r;
   endfunction

   task automatic push(input int c, input int v, output bit acc);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_chan  = CH_W'(c);
      cmd_vol   = VOL_W'(v);
      acc = cmd_ready;
      @(posedge clk);
      if (acc) q.push_back(mk(c, v));
   endtask

   task automatic release_cmd();
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while ((q.size() != 0 || busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("drain_queue", q.size(), 0);
   endtask

   function automatic void clear_track();
      open_cnt = 0; closed_cnt = 0; pump_cnt = 0; since = 0; bad_valve = 0; bad_gap = 0;
   endfunction

   // Monitor: accumulate valve/pump behaviour per command and score it on each done/err pulse.
   always @(negedge clk) begin
      logic [NUM_CH-1:0] one;
      one = 1;
      if (rst) begin
         clear_track();
      end else begin
         if (valve_sel != 0) begin
            if (q.size() > 0 && valve_sel == (one << q[0].chan)) open_cnt++;
            else bad_valve++;
            closed_cnt = 0;
         end else if (open_cnt > 0) begin
            closed_cnt++;
         end
         if (pump_step) begin
            if (valve_sel == 0) bad_valve++;
            if (pump_cnt == 0 && open_cnt != VALVE_LEAD + 1) bad_gap++;
            if (pump_cnt > 0 && since != STEP_DIV) bad_gap++;
            pump_cnt++;
            since = 0;
         end
         since++;
         if (done_pulse || err_pulse) begin
            if (q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_event: done=%0b err=%0b with empty queue", done_pulse, err_pulse);
            end else begin
               e_cur = q.pop_front();
               chk("event_is_err", int'(err_pulse), int'(e_cur.err));
               chk("event_is_done", int'(done_pulse), int'(!e_cur.err));
               if (!e_cur.err && e_cur.steps > 0) chk("steps_done", int'(steps_done), e_cur.steps);
               chk("pump_pulses", pump_cnt, e_cur.steps);
               chk("valve_open_cycles", open_cnt, e_cur.open);
               chk("settle_cycles", closed_cnt, e_cur.settle);
               chk("wrong_valve", bad_valve, 0);
               chk("pump_spacing", bad_gap, 0);
            end
            clear_track();
         end
      end
   end

   initial begin
      bit acc;
      int n, n_acc;
      rst = 1'b1;
      cmd_valid = 1'b0;
      cmd_chan = '0;
      cmd_vol = '0;
`ifdef ABORT_DISPENSE_EN
      abort = 1'b0;
`endif
      repeat (3) @(negedge clk);
      chk("rst_valve", int'(valve_sel), 0);
      chk("rst_ready", int'(cmd_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_steps", int'(steps_done), 0);
      rst = 1'b0;

      // Reset mid-pump: valve must shut and the queue forget the partial command.
      push(2, 3, acc);
      release_cmd();
      n = 0;
      while (!pump_step && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("reach_pump", int'(pump_step), 1);
      rst = 1'b1;
      q.delete();
      #1;
      chk("midrst_valve", int'(valve_sel), 0);
      chk("midrst_pump", int'(pump_step), 0);
      chk("midrst_ready", int'(cmd_ready), 1);
      chk("midrst_busy", int'(busy), 0);
      @(negedge clk);
      rst = 1'b0;

      // Single nominal dispense, then bad channels and zero volume.
      push(5, 3, acc);
      release_cmd();
      wait_drain(2000);
      push(9, 3, acc);
      push(8, 1, acc);
      push(7, 0, acc);
      push(0, 1, acc);
      release_cmd();
      wait_drain(2000);

      // Back-to-back pushes while idle: the first is popped at once, then the FIFO fills.
      n_acc = 0;
      for (int i = 0; i < CMD_DEPTH + 2; i++) begin
         push(i % NUM_CH, 2, acc);
         if (acc) n_acc++;
      end
      @(negedge clk);
      chk("ready_when_full", int'(cmd_ready), 0);
      cmd_valid = 1'b0;
      chk("accepted_count", n_acc, CMD_DEPTH + 1);
      wait_drain(5000);

`ifdef ABORT_DISPENSE_EN
      push(3, 10, acc);
      push(4, 1, acc);
      release_cmd();
      n = 0;
      pump_cnt = pump_cnt;
      begin
         int seen = 0;
         while (seen < 3 && n < 500) begin
            @(negedge clk);
            if (pump_step) seen++;
            n++;
         end
         chk("abort_reach_step3", seen, 3);
      end
      abort = 1'b1;
      q[0].steps = 3;
      q[0].open  = VALVE_LEAD + 2 * STEP_DIV + 1;
      @(negedge clk);
      abort = 1'b0;
      wait_drain(2000);
`endif

      // Randomised traffic with idle gaps, retrying while the FIFO is full.
      for (int k = 0; k < 30; k++) begin
         n = 0;
         push($urandom_range(0, 9), $urandom_range(0, 4), acc);
         while (!acc && n < 2000) begin
            push(int'(cmd_chan), int'(cmd_vol), acc);
            n++;
         end
         if (!acc) chk("push_timeout", 0, 1);
         if ($urandom_range(0, 2) != 0) begin
            release_cmd();
            repeat ($urandom_range(0, 40)) @(negedge clk);
         end
      end
      release_cmd();
      wait_drain(20000);
      chk("final_busy", int'(busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
